// File: rtl/ifu.sv
// Instruction fetch: one outstanding word fetch; the fetched word is held for decode under valid/ready.
// Response-to-inst_valid is 1 cycle; inst_ready low holds HOLD and no new fetch; a redirect kills in-flight work.
module ifu #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] PC_RST = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_ready,
  input  logic            ibus_rvalid,
  input  logic [XLEN-1:0] ibus_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] target;

  assign target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      inst_q    <= '0;
      inst_pc_q <= PC_RST;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    drop_d    = drop_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = target;
      end
      S_REQ: begin
        if (ibus_ready) state_d = S_WAIT;
        if (redirect_valid) begin
          pc_d = target;
          // The old address was already accepted; its response must be thrown away.
          if (ibus_ready) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
          if (redirect_valid) begin
            pc_d = target;
          end else if (!drop_q) begin
            inst_d    = ibus_rdata;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ibus_req   = (state_q == S_REQ);
  assign ibus_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: bus/decode/redirect stimulus plus a transaction-level
// model of the architectural PC stream; a negedge monitor scores every delivered word.
module tb_ifu;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu #(.XLEN(32), .PC_RST(PC_RST)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ready    (ibus_ready),
    .ibus_rvalid   (ibus_rvalid),
    .ibus_rdata    (ibus_rdata),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } exp_t;

  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Stimulus knobs (percent probabilities) owned by the main process.
  int          p_ready = 100, p_iready = 100, p_redir = 0, fixed_wait = 0;
  bit          force_redir = 0;
  logic [31:0] force_pc = '0;

  // Bus/architectural model owned by the monitor.
  logic [31:0] exp_pc = PC_RST;
  bit          pend = 0, pend_live = 0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = '0;
  int          delivered = 0;
  int          cov_acc_redir = 0, cov_rv_redir = 0, cov_hold_redir = 0, cov_wait_redir = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7) == 0) t = 32'hFFFF_FFFC | (t & 32'h3);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ibus_ready = (int'($urandom_range(99)) < p_ready);
    inst_ready = (int'($urandom_range(99)) < p_iready);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 0;
    end else begin
      redirect_valid = (int'($urandom_range(99)) < p_redir);
      redirect_pc    = rand_target();
    end
    ibus_rvalid = pend && (pend_wait == 0);
    ibus_rdata  = $urandom;
  endtask

  // Transaction-level monitor: compares each held word, then advances the model for the coming edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      expq.delete();
      exp_pc = PC_RST;
      pend   = 0;
    end else begin
      if (inst_valid) begin
        if (expq.size() == 0) begin
          timeout("inst_unexpected");
        end else begin
          chk("inst", inst, expq[0].dat);
          chk("inst_pc", inst_pc, expq[0].pc);
          chk("inst_pc_arch", inst_pc, exp_pc);
          if (inst_ready || redirect_valid) void'(expq.pop_front());
          if (inst_ready && !redirect_valid) delivered++;
          if (redirect_valid && inst_ready) cov_hold_redir++;
        end
      end
      if (ibus_rvalid) begin
        if (!pend) timeout("rvalid_without_request");
        else if (pend_live && !redirect_valid) expq.push_back({ibus_rdata, pend_addr});
        if (redirect_valid) cov_rv_redir++;
        pend = 0;
      end else if (pend) begin
        if (redirect_valid) cov_wait_redir++;
        if (pend_wait > 0) pend_wait--;
      end
      if (ibus_req && ibus_ready) begin
        chk("one_outstanding", 32'(pend), 32'd0);
        chk("fetch_addr", ibus_addr, exp_pc);
        pend      = 1;
        pend_live = 1;
        pend_addr = ibus_addr;
        pend_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3));
        if (redirect_valid) cov_acc_redir++;
      end
      if (redirect_valid) begin
        pend_live = 0;
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
      end else if (inst_valid && inst_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ibus_req"}, 32'(ibus_req), 32'd0);
    chk({tag, "_ibus_addr"}, ibus_addr, PC_RST);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, PC_RST);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic step_until_req(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ibus_req) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(nm);
  endtask

  initial begin
    logic [11:0] vbits, rbits;
    logic [31:0] held_pc;
    bit          ok;
    int          seen_valid;

    rst_b = 1'b0; ibus_ready = 0; ibus_rvalid = 0; ibus_rdata = '0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Back-to-back fetches with zero bus latency: one instruction every 3 cycles.
    step();
    rst_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vbits[c] = inst_valid;
      rbits[c] = ibus_req;
      step();
    end
    chk("valid_pattern", 32'(vbits), 32'h248);
    chk("req_pattern", 32'(rbits), 32'h492);

    // Decode backpressure.
    p_iready = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      ok = inst_valid;
    end
    if (!ok) timeout("bp_wait_valid");
    held_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_held", 32'(inst_valid), 32'd1);
      chk("bp_no_req", 32'(ibus_req), 32'd0);
    end
    p_iready = 100;
    step_until_req("bp_wait_req", ok);
    chk("bp_next_addr", ibus_addr, held_pc + 32'd4);

    // Redirect while waiting; the late response is discarded.
    fixed_wait = 3;
    for (int i = 0; i < 30 && !(ibus_req && ibus_ready); i++) step();
    force_redir = 1; force_pc = 32'h8000_0102;
    seen_valid = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (inst_valid) seen_valid++;
      if (ibus_req) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("rw_wait_req");
    chk("rw_no_valid", 32'(seen_valid), 32'd0);
    chk("rw_addr", ibus_addr, 32'h8000_0100);

    // Redirect in REQ while the bus stalls: address switches, nothing dropped.
    fixed_wait = 0;
    p_ready = 0;
    step_until_req("rq_wait_req", ok);
    force_redir = 1; force_pc = 32'h1234_567B;
    step();
    step();
    chk("rq_req", 32'(ibus_req), 32'd1);
    chk("rq_addr", ibus_addr, 32'h1234_5678);
    p_ready = 100;

    // PC wrap at the top of the address space.
    force_redir = 1; force_pc = 32'hFFFF_FFFF;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      ok = inst_valid;
    end
    if (!ok) timeout("wrap_wait_valid");
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step_until_req("wrap_wait_req", ok);
    chk("wrap_addr", ibus_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of a fetch.
    fixed_wait = 3;
    for (int i = 0; i < 30 && !(ibus_req && ibus_ready); i++) step();
    step();
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_outputs("arst");
    step();
    step();
    rst_b = 1'b1;
    step_until_req("arst_wait_req", ok);
    chk("arst_refetch", ibus_addr, PC_RST);

    // Randomized traffic against the model.
    fixed_wait = -1;
    p_ready = 70; p_iready = 60; p_redir = 12;
    for (int i = 0; i < 4000; i++) step();
    p_redir = 0;
    repeat (20) step();

    chk("delivered_some", 32'(delivered > 50), 32'd1);
    chk("cov_redir_on_accept", 32'(cov_acc_redir > 0), 32'd1);
    chk("cov_redir_on_rvalid", 32'(cov_rv_redir > 0), 32'd1);
    chk("cov_redir_in_wait", 32'(cov_wait_redir > 0), 32'd1);
    chk("cov_redir_on_hold_ready", 32'(cov_hold_redir > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
